// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
//   Shared constants and types for the calculator adder core.
//
//   ADDER_DEFAULT_W  default operand/sum width used when the adder is
//                    instantiated without an explicit width.
//   ADDER_MAX_W      widest supported operand width.
//   adder_result_t   full-precision result container {cout, sum}. It is sized
//                    for the widest supported adder; an n-bit instance uses
//                    bits [n:0], with bit n holding the carry out.
//   adder_pack       helper that builds an adder_result_t from a carry and an
//                    n-bit sum (sum supplied zero-extended to ADDER_MAX_W).
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_DEFAULT_W = 4;
    localparam int ADDER_MAX_W     = 64;

    typedef logic [ADDER_MAX_W:0] adder_result_t;

    // Place the carry directly above the top sum bit for a width-w adder.
    function automatic adder_result_t adder_pack(
        input logic                   carry,
        input logic [ADDER_MAX_W-1:0] sum_ext,
        input int                     w
    );
        adder_result_t r;
        r      = {1'b0, sum_ext};
        r[w]   = carry;
        return r;
    endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// -----------------------------------------------------------------------------
// full_adder_1bit
//   One stage of the ripple-carry chain.
//
//   Ports
//     a   in   1   operand bit
//     b   in   1   operand bit
//     ci  in   1   carry into this bit
//     s   out  1   sum bit  = a ^ b ^ ci
//     co  out  1   carry out = generate | (propagate & ci)
// -----------------------------------------------------------------------------
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/adder_n_bit.sv
// -----------------------------------------------------------------------------
// adder_n_bit
//   Registered n-bit unsigned ripple-carry adder, arithmetic core of the
//   calculator datapath. Operands and carry-in are sampled on every rising
//   clock edge where in_valid is high; the result appears on the outputs one
//   clock later together with out_valid.
//
//   Parameters
//     n          operand/sum width, 1..64 (default ADDER_DEFAULT_W = 4)
//
//   Ports
//     clk        in   1   rising-edge clock
//     rst_n      in   1   asynchronous active-low reset
//     in_valid   in   1   a/b/cin qualify this cycle
//     a          in   n   operand A, unsigned
//     b          in   n   operand B, unsigned
//     cin        in   1   carry-in
//     out_valid  out  1   sum/cout hold a result loaded on the last edge
//     sum        out  n   registered (a + b + cin) mod 2^n
//     cout       out  1   registered carry out of bit n-1
//     ovf        out  1   registered two's-complement overflow
//                         (only when ADDER_OVF_EN is defined)
//
//   Build options
//     ADDER_OVF_EN  adds the ovf port and its register. Without it the port
//                   and register are absent and everything else is unchanged.
//
//   When in_valid is low the result registers keep their contents and only
//   out_valid drops, so downstream logic can still read the last result.
// -----------------------------------------------------------------------------
module adder_n_bit
    import adder_pkg::*;
#(
    parameter int n = ADDER_DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    output logic [n-1:0] sum,
    output logic         cout
`ifdef ADDER_OVF_EN
    ,
    output logic         ovf
`endif
);

    // ---- stage p0: combinational ripple chain on the live inputs ----------
    logic [n:0]   c_p0;
    logic [n-1:0] s_p0;

    assign c_p0[0] = cin;

    for (genvar i = 0; i < n; i++) begin : g_bit
        full_adder_1bit u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c_p0[i]),
            .s  (s_p0[i]),
            .co (c_p0[i+1])
        );
    end

    // ---- stage p1: result, carry and valid registers ----------------------
    logic [n-1:0] sum_p1;
    logic         cout_p1;
    logic         vld_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1  <= s_p0;
                cout_p1 <= c_p0[n];
            end
        end
    end

    assign out_valid = vld_p1;
    assign sum       = sum_p1;
    assign cout      = cout_p1;

`ifdef ADDER_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    // For n == 1 the carry into the sign bit is cin itself.
    logic ovf_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_p1 <= 1'b0;
        end else if (in_valid) begin
            ovf_p1 <= c_p0[n] ^ c_p0[n-1];
        end
    end

    assign ovf = ovf_p1;
`endif

endmodule

// File: tb/tb_adder_n_bit.sv
module tb_adder_n_bit;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [N-1:0] sum;
    logic         cout;
`ifdef ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    adder_n_bit #(.n(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
`ifdef ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: unsigned total of the operands as a plain integer.
    function automatic int ref_total(input int av, input int bv, input int cv);
        return av + bv + cv;
    endfunction

    // Reference: signed overflow from value range of the n-bit signed sum.
    function automatic logic ref_ovf(input int av, input int bv, input int cv);
        int sa, sb, t;
        sa = (av >= (1 << (N-1))) ? av - (1 << N) : av;
        sb = (bv >= (1 << (N-1))) ? bv - (1 << N) : bv;
        t  = sa + sb + cv;
        return (t > (1 << (N-1)) - 1) || (t < -(1 << (N-1)));
    endfunction

    // Drive one operand set at the falling edge, return #1 after the next rising edge.
    task automatic apply(input int av, input int bv, input int cv, input logic vld);
        @(negedge clk);
        a        = av[N-1:0];
        b        = bv[N-1:0];
        cin      = cv[0];
        in_valid = vld;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a = '0; b = '0; cin = 1'b0; in_valid = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, cout, sum} !== {1'b0, 1'b0, {N{1'b0}}}) begin
            failures++;
            $display("FAIL reset_async: got valid=%b cout=%b sum=%h want 0 0 0", out_valid, cout, sum);
        end
        apply(3, 5, 1, 1'b1);
        checks++;
        if ({out_valid, cout, sum} !== {1'b0, 1'b0, {N{1'b0}}}) begin
            failures++;
            $display("FAIL reset_held: got valid=%b cout=%b sum=%h want 0 0 0", out_valid, cout, sum);
        end
`ifdef ADDER_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    task automatic test_directed();
        int va[6] = '{1, 9, 5, 15, 15, 7};
        int vb[6] = '{2, 6, 11, 1, 15, 1};
        int vc[6] = '{0, 0, 0, 0, 0, 1};
        int ws[6] = '{3, 15, 0, 0, 14, 9};
        int wc[6] = '{0, 0, 1, 1, 1, 0};
        for (int i = 0; i < 6; i++) begin
            apply(va[i], vb[i], vc[i], 1'b1);
            checks++;
            if ({out_valid, cout, sum} !== {1'b1, wc[i][0], ws[i][N-1:0]}) begin
                failures++;
                $display("FAIL directed_%0d: got valid=%b cout=%b sum=%h want 1 %b %h",
                         i, out_valid, cout, sum, wc[i][0], ws[i][N-1:0]);
            end
`ifdef ADDER_OVF_EN
            checks++;
            if (ovf !== ref_ovf(va[i], vb[i], vc[i])) begin
                failures++;
                $display("FAIL directed_ovf_%0d: got %b want %b", i, ovf, ref_ovf(va[i], vb[i], vc[i]));
            end
`endif
        end
    endtask

    task automatic test_hold();
        int t;
        apply(6, 7, 1, 1'b1);
        t = ref_total(6, 7, 1);
        for (int k = 0; k < 3; k++) begin
            apply(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 1)), 1'b0);
            checks++;
            if ({out_valid, cout, sum} !== {1'b0, t[N], t[N-1:0]}) begin
                failures++;
                $display("FAIL hold_%0d: got valid=%b cout=%b sum=%h want 0 %b %h",
                         k, out_valid, cout, sum, t[N], t[N-1:0]);
            end
        end
    endtask

    task automatic test_async_midstream();
        int t;
        apply(12, 9, 0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, cout, sum} !== {1'b0, 1'b0, {N{1'b0}}}) begin
            failures++;
            $display("FAIL mid_reset_immediate: got valid=%b cout=%b sum=%h want 0 0 0", out_valid, cout, sum);
        end
        apply(10, 10, 1, 1'b1);
        checks++;
        if ({out_valid, cout, sum} !== {1'b0, 1'b0, {N{1'b0}}}) begin
            failures++;
            $display("FAIL mid_reset_held: got valid=%b cout=%b sum=%h want 0 0 0", out_valid, cout, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        a = 4'd13; b = 4'd4; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        #1;
        t = ref_total(13, 4, 1);
        checks++;
        if ({out_valid, cout, sum} !== {1'b1, t[N], t[N-1:0]}) begin
            failures++;
            $display("FAIL mid_reset_first: got valid=%b cout=%b sum=%h want 1 %b %h",
                     out_valid, cout, sum, t[N], t[N-1:0]);
        end
    endtask

    task automatic test_sweep();
        int t;
        int errs = 0;
        for (int av = 0; av < 16; av++)
            for (int bv = 0; bv < 16; bv++)
                for (int cv = 0; cv < 2; cv++) begin
                    apply(av, bv, cv, 1'b1);
                    t = ref_total(av, bv, cv);
                    checks++;
                    if ({out_valid, cout, sum} !== {1'b1, t[N], t[N-1:0]}) begin
                        failures++;
                        errs++;
                        if (errs <= 10)
                            $display("FAIL sweep a=%0d b=%0d cin=%0d: got valid=%b cout=%b sum=%h want 1 %b %h",
                                     av, bv, cv, out_valid, cout, sum, t[N], t[N-1:0]);
                    end
`ifdef ADDER_OVF_EN
                    checks++;
                    if (ovf !== ref_ovf(av, bv, cv)) begin
                        failures++;
                        errs++;
                        if (errs <= 10)
                            $display("FAIL sweep_ovf a=%0d b=%0d cin=%0d: got %b want %b",
                                     av, bv, cv, ovf, ref_ovf(av, bv, cv));
                    end
`endif
                end
    endtask

    task automatic test_random_valid();
        int   last_t;
        int   av, bv, cv, t;
        logic vld;
        int   errs = 0;
        // Establish a known held result first.
        apply(0, 0, 0, 1'b1);
        last_t = 0;
        for (int k = 0; k < 300; k++) begin
            av  = int'($urandom_range(0, 15));
            bv  = int'($urandom_range(0, 15));
            cv  = int'($urandom_range(0, 1));
            vld = ($urandom_range(0, 3) != 0);
            apply(av, bv, cv, vld);
            if (vld) last_t = ref_total(av, bv, cv);
            t = last_t;
            checks++;
            if ({out_valid, cout, sum} !== {vld, t[N], t[N-1:0]}) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: got valid=%b cout=%b sum=%h want %b %b %h",
                             k, out_valid, cout, sum, vld, t[N], t[N-1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_async_midstream();
        test_sweep();
        test_random_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
